// File: rtl/lz_restore_if.sv
// lz_restore_if: handshake and payload bundle between a producer and the lz_restore pipeline
interface lz_restore_if;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] in_data;
  logic [5:0]  in_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_data;
  logic        out_sticky;
  logic        out_ovf;
  modport master (output in_valid, in_data, in_cnt, out_ready,
                  input  in_ready, out_valid, out_data, out_sticky, out_ovf);
  modport slave  (input  in_valid, in_data, in_cnt, out_ready,
                  output in_ready, out_valid, out_data, out_sticky, out_ovf);
endinterface

// File: rtl/lz_restore.sv
// lz_restore: three-stage right-shift denormalizer with sticky and overflow flags
module lz_restore (
  input logic        clk,
  input logic        rst,
  lz_restore_if.slave io
);
  logic        v1, v2, v3, st1, st2, st3, o1, o2, o3, en1, en2, en3;
  logic [30:0] d1, d2, d3;
  logic [3:0]  c1;
  logic [1:0]  c2;
  logic [31:0] r1, r2, r3;
  // {sticky of dropped bits, shifted word}; shifts of 31+ drop the whole word
  function automatic logic [31:0] shr(input logic [30:0] d, input logic [5:0] s);
    return {|(d & ~(31'h7FFF_FFFF << s)), d >> s};
  endfunction
  always_comb begin
    en3 = ~v3 | io.out_ready;
    en2 = ~v2 | en3;
    en1 = ~v1 | en2;
    r1  = shr(io.in_data, {io.in_cnt[5:4], 4'b0});
    r2  = shr(d1, {2'b0, c1[3:2], 2'b0});
    r3  = shr(d2, {4'b0, c2});
  end
  assign io.in_ready   = en1;
  assign io.out_valid  = v3;
  assign io.out_data   = d3;
  assign io.out_sticky = st3;
  assign io.out_ovf    = o3;
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3, st1, st2, st3, o1, o2, o3} <= '0;
      {d1, d2, d3} <= '0;
      c1 <= '0;
      c2 <= '0;
    end else begin
      if (en1) begin
        v1  <= io.in_valid;
        d1  <= r1[30:0];
        st1 <= r1[31];
        o1  <= io.in_cnt[5];
        c1  <= io.in_cnt[3:0];
      end
      if (en2) begin
        v2  <= v1;
        d2  <= r2[30:0];
        st2 <= st1 | r2[31];
        o2  <= o1;
        c2  <= c1[1:0];
      end
      if (en3) begin
        v3  <= v2;
        d3  <= r3[30:0];
        st3 <= st2 | r3[31];
        o3  <= o2;
      end
    end
  end
endmodule
